// File: rtl/run_mode_controller.sv
// JPEG-LS run-mode controller: counts run pixels against J[RUNindex],
// emits hit/EOL/tail code words and hands interruptions to the encoder.
module run_mode_controller #(
    parameter int J_length            = 5,
    parameter int runcount_length     = 16,
    parameter int encodedpixel_width  = 32,
    parameter int encodedlength_width = 6
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           frame_start,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    input  logic                           pix_match,
    input  logic                           pix_eol,
    output logic                           code_valid,
    input  logic                           code_ready,
    output logic [encodedpixel_width-1:0]  code_bits,
    output logic [encodedlength_width-1:0] code_length,
    output logic                           intr_valid,
    output logic [J_length-1:0]            intr_index,
    output logic [J_length-1:0]            run_index
);

    localparam logic [J_length-1:0] IDX_MAX = '1;

    function automatic logic [J_length-1:0] j_rom(input logic [J_length-1:0] idx);
        logic [J_length-1:0] j;
        j = '0;
        case (int'(idx))
            0, 1, 2, 3:     j = J_length'(0);
            4, 5, 6, 7:     j = J_length'(1);
            8, 9, 10, 11:   j = J_length'(2);
            12, 13, 14, 15: j = J_length'(3);
            16, 17:         j = J_length'(4);
            18, 19:         j = J_length'(5);
            20, 21:         j = J_length'(6);
            22, 23:         j = J_length'(7);
            default:        j = J_length'(int'(idx) - 16);
        endcase
        return j;
    endfunction

    logic [runcount_length-1:0]     run_count_q, run_count_d;
    logic [J_length-1:0]            run_index_q, run_index_d;
    logic                           code_valid_q, code_valid_d;
    logic [encodedpixel_width-1:0]  code_bits_q, code_bits_d;
    logic [encodedlength_width-1:0] code_length_q, code_length_d;
    logic                           intr_valid_q, intr_valid_d;
    logic [J_length-1:0]            intr_index_q, intr_index_d;

    logic [J_length-1:0]        j_cur;
    logic [runcount_length-1:0] rm;
    logic [runcount_length-1:0] cnt_next;
    logic                       accept;

    assign pix_ready = reset_n && !frame_start && (!code_valid_q || code_ready);
    assign accept    = pix_valid && pix_ready;
    assign j_cur     = j_rom(run_index_q);
    assign rm        = runcount_length'(1) << j_cur;
    assign cnt_next  = run_count_q + runcount_length'(1);

    always_comb begin
        run_count_d   = run_count_q;
        run_index_d   = run_index_q;
        code_valid_d  = code_valid_q;
        code_bits_d   = code_bits_q;
        code_length_d = code_length_q;
        intr_valid_d  = 1'b0;
        intr_index_d  = intr_index_q;

        if (code_valid_q && code_ready) begin
            code_valid_d = 1'b0;
        end

        if (frame_start) begin
            run_count_d = '0;
            run_index_d = '0;
        end else if (accept) begin
            if (pix_match) begin
                if (cnt_next == rm || pix_eol) begin
                    code_valid_d  = 1'b1;
                    code_bits_d   = encodedpixel_width'(1);
                    code_length_d = encodedlength_width'(1);
                    run_count_d   = '0;
                    // Only a full run advances RUNindex; a partial EOL run does not
                    if (cnt_next == rm && run_index_q != IDX_MAX) begin
                        run_index_d = run_index_q + J_length'(1);
                    end
                end else begin
                    run_count_d = cnt_next;
                end
            end else begin
                code_valid_d  = 1'b1;
                code_bits_d   = encodedpixel_width'(run_count_q & (rm - runcount_length'(1)));
                code_length_d = encodedlength_width'(j_cur) + encodedlength_width'(1);
                intr_valid_d  = 1'b1;
                intr_index_d  = run_index_q;
                run_count_d   = '0;
                if (run_index_q != '0) begin
                    run_index_d = run_index_q - J_length'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_count_q   <= '0;
            run_index_q   <= '0;
            code_valid_q  <= 1'b0;
            code_bits_q   <= '0;
            code_length_q <= '0;
            intr_valid_q  <= 1'b0;
            intr_index_q  <= '0;
        end else begin
            run_count_q   <= run_count_d;
            run_index_q   <= run_index_d;
            code_valid_q  <= code_valid_d;
            code_bits_q   <= code_bits_d;
            code_length_q <= code_length_d;
            intr_valid_q  <= intr_valid_d;
            intr_index_q  <= intr_index_d;
        end
    end

    assign code_valid  = code_valid_q;
    assign code_bits   = code_bits_q;
    assign code_length = code_length_q;
    assign intr_valid  = intr_valid_q;
    assign intr_index  = intr_index_q;
    assign run_index   = run_index_q;

endmodule

// File: tb/tb_run_mode_controller.sv
// Directed bench for run_mode_controller: hits, EOL, tails, floor,
// saturation, backpressure, frame_start and reset-mid-stall.
module tb_run_mode_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_match;
    logic        pix_eol;
    logic        code_valid;
    logic        code_ready;
    logic [31:0] code_bits;
    logic [5:0]  code_length;
    logic        intr_valid;
    logic [4:0]  intr_index;
    logic [4:0]  run_index;

    int checks = 0;
    int errors = 0;

    run_mode_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_match   (pix_match),
        .pix_eol     (pix_eol),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .code_bits   (code_bits),
        .code_length (code_length),
        .intr_valid  (intr_valid),
        .intr_index  (intr_index),
        .run_index   (run_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_code(input string tag, input logic ev, input logic [31:0] eb,
                            input logic [5:0] el, input logic [4:0] eri);
        chk({tag, "_valid"}, 32'(code_valid), 32'(ev));
        if (ev) begin
            chk({tag, "_bits"}, code_bits, eb);
            chk({tag, "_len"}, 32'(code_length), 32'(el));
        end
        chk({tag, "_ridx"}, 32'(run_index), 32'(eri));
    endtask

    task automatic chk_intr(input string tag, input logic ev, input logic [4:0] ei);
        chk({tag, "_ivalid"}, 32'(intr_valid), 32'(ev));
        if (ev) chk({tag, "_iidx"}, 32'(intr_index), 32'(ei));
    endtask

    task automatic px(input logic m, input logic e, input bit do_chk);
        pix_valid = 1'b1;
        pix_match = m;
        pix_eol   = e;
        #1;
        if (do_chk) chk("pix_ready", 32'(pix_ready), 32'd1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_match = 1'b0;
        pix_eol   = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_match   = 1'b0;
        pix_eol     = 1'b0;
        code_ready  = 1'b1;
        idle();
        idle();
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_code_valid", 32'(code_valid), 32'd0);
        chk("rst_code_bits", code_bits, 32'd0);
        chk("rst_code_len", 32'(code_length), 32'd0);
        chk("rst_intr_valid", 32'(intr_valid), 32'd0);
        chk("rst_intr_index", 32'(intr_index), 32'd0);
        chk("rst_run_index", 32'(run_index), 32'd0);
        reset_n = 1'b1;
        idle();

        // Four hits at rm=1
        for (int i = 0; i < 4; i++) begin
            px(1'b1, 1'b0, 1'b1);
            chk_code("hit0", 1'b1, 32'd1, 6'd1, 5'(i + 1));
        end

        // RUNindex 4: one match then tail {0,1}
        px(1'b1, 1'b0, 1'b1);
        chk_code("idx4_match", 1'b0, 32'd0, 6'd0, 5'd4);
        px(1'b0, 1'b0, 1'b1);
        chk_code("idx4_tail", 1'b1, 32'd1, 6'd2, 5'd3);
        chk_intr("idx4_tail", 1'b1, 5'd4);
        idle();
        chk_intr("idx4_after", 1'b0, 5'd0);
        chk_code("idx4_after", 1'b0, 32'd0, 6'd0, 5'd3);

        // Interruptions walk RUNindex 3 -> 0, then floor at 0
        for (int i = 3; i >= 1; i--) begin
            px(1'b0, 1'b0, 1'b1);
            chk_code("walk_tail", 1'b1, 32'd0, 6'd1, 5'(i - 1));
            chk_intr("walk_tail", 1'b1, 5'(i));
        end
        px(1'b0, 1'b1, 1'b1);
        chk_code("floor_tail", 1'b1, 32'd0, 6'd1, 5'd0);
        chk_intr("floor_tail", 1'b1, 5'd0);

        // 4 hits at rm=1 and 8 pixels at rm=2 -> RUNindex 8
        for (int i = 0; i < 12; i++) px(1'b1, 1'b0, 1'b0);
        chk_code("to8", 1'b1, 32'd1, 6'd1, 5'd8);

        // rm=4: partial run of 3 ending on EOL
        px(1'b1, 1'b0, 1'b1);
        chk_code("eol_p1", 1'b0, 32'd0, 6'd0, 5'd8);
        px(1'b1, 1'b0, 1'b1);
        chk_code("eol_p2", 1'b0, 32'd0, 6'd0, 5'd8);
        px(1'b1, 1'b1, 1'b1);
        chk_code("eol_p3", 1'b1, 32'd1, 6'd1, 5'd8);

        // Full run of 4 with EOL on the hit: exactly one word
        for (int i = 0; i < 3; i++) begin
            px(1'b1, 1'b0, 1'b1);
            chk_code("hiteol_p", 1'b0, 32'd0, 6'd0, 5'd8);
        end
        px(1'b1, 1'b1, 1'b1);
        chk_code("hiteol_hit", 1'b1, 32'd1, 6'd1, 5'd9);
        idle();
        chk_code("hiteol_once", 1'b0, 32'd0, 6'd0, 5'd9);

        // Backpressure on a tail word at RUNindex 9 (J=2) with run_count 1
        px(1'b1, 1'b0, 1'b1);
        code_ready = 1'b0;
        px(1'b0, 1'b0, 1'b1);
        chk_code("bp_tail", 1'b1, 32'd1, 6'd3, 5'd8);
        chk_intr("bp_tail", 1'b1, 5'd9);
        pix_valid = 1'b1;
        pix_match = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_pix_ready", 32'(pix_ready), 32'd0);
            @(posedge clk);
            #1;
            chk_code("bp_hold", 1'b1, 32'd1, 6'd3, 5'd8);
            chk_intr("bp_hold", 1'b0, 5'd0);
        end
        code_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(pix_ready), 32'd1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_match = 1'b0;
        chk_code("bp_release", 1'b0, 32'd0, 6'd0, 5'd8);
        px(1'b1, 1'b0, 1'b1);
        chk_code("bp_p2", 1'b0, 32'd0, 6'd0, 5'd8);
        px(1'b1, 1'b0, 1'b1);
        chk_code("bp_p3", 1'b0, 32'd0, 6'd0, 5'd8);
        px(1'b1, 1'b0, 1'b1);
        chk_code("bp_p4", 1'b1, 32'd1, 6'd1, 5'd9);

        // Climb from RUNindex 9 to 31: sum of rm over indices 9..30
        for (int i = 0; i < 33036; i++) px(1'b1, 1'b0, 1'b0);
        chk_code("to31", 1'b1, 32'd1, 6'd1, 5'd31);

        // Full run at 31 (rm=32768) saturates RUNindex
        for (int i = 0; i < 32767; i++) px(1'b1, 1'b0, 1'b0);
        chk_code("sat_pre", 1'b0, 32'd0, 6'd0, 5'd31);
        px(1'b1, 1'b0, 1'b1);
        chk_code("sat_hit", 1'b1, 32'd1, 6'd1, 5'd31);

        // Build run_count=100 at 31, then frame_start with a pixel
        for (int i = 0; i < 100; i++) px(1'b1, 1'b0, 1'b0);
        chk_code("rc100", 1'b0, 32'd0, 6'd0, 5'd31);
        frame_start = 1'b1;
        pix_valid   = 1'b1;
        pix_match   = 1'b1;
        #1;
        chk("fs_pix_ready", 32'(pix_ready), 32'd0);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_match   = 1'b0;
        chk_code("fs_after", 1'b0, 32'd0, 6'd0, 5'd0);
        px(1'b1, 1'b0, 1'b1);
        chk_code("fs_hit", 1'b1, 32'd1, 6'd1, 5'd1);

        // Reset during a stall discards the pending word
        idle();
        code_ready = 1'b0;
        px(1'b0, 1'b0, 1'b1);
        chk_code("rs_tail", 1'b1, 32'd0, 6'd1, 5'd0);
        chk_intr("rs_tail", 1'b1, 5'd1);
        reset_n = 1'b0;
        idle();
        chk_code("rs_after", 1'b0, 32'd0, 6'd0, 5'd0);
        chk("rs_pix_ready", 32'(pix_ready), 32'd0);
        chk("rs_code_bits", code_bits, 32'd0);
        reset_n    = 1'b1;
        code_ready = 1'b1;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
